i2s_tx_frame: RTL and testbench

- Parametrised I2S/left-justified/TDM serial audio transmitter.
- Runs entirely on the system clock: bclk and lrclk come from internal counters, not from a PLL or external dividers.
- Accepts one frame of samples (all channels) over a valid/ready handshake into a single-entry holding buffer.
- Serialises frames continuously and reports underrun; it sits between the synth voice mixer and the DAC pins.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_clkgen.sv | 56 +++++
 rtl/i2s_tx_frame.sv | 138 +++++++++++++
 tb/tb_i2s_tx_frame.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the i2s_tx_frame serial audio transmitter.
package i2s_pkg;

  // Data alignment modes
  localparam int MODE_I2S = 0;  // data delayed one bclk after slot start
  localparam int MODE_LJ  = 1;  // data aligned to slot start

  // Number of bclk periods in one frame (all channel slots)
  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides sclk into bclk and tracks the bit position
// inside the frame. tick marks the sclk cycle on which bclk falls and the
// bit position advances; frame_wrap marks the tick that wraps to bit 0.
module i2s_clkgen #(
  parameter int BCLK_DIV   = 4,
  parameter int FRAME_BITS = 64,
  localparam int CNT_W     = $clog2(FRAME_BITS)
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  output logic             bclk_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] bit_cnt_o,
  output logic             frame_wrap_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bclk_q, bclk_d;

  assign tick_o       = (div_cnt_q == DIV_LAST);
  assign frame_wrap_o = tick_o && (bit_cnt_q == BIT_LAST);
  assign bclk_o       = bclk_q;
  assign bit_cnt_o    = bit_cnt_q;

  // Next-state: divider wraps on tick, bclk rises mid-period and falls on tick
  always_comb begin
    div_cnt_d = tick_o ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    bit_cnt_d = bit_cnt_q;
    if (div_cnt_q == DIV_RISE) bclk_d = 1'b1;
    if (tick_o) begin
      bclk_d    = 1'b0;
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset parks bit_cnt on the last bit so the first tick loads
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_LAST;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx_frame.sv
// I2S / left-justified / TDM transmitter running on the system clock.
// A whole frame is accepted into a single-entry holding buffer and loaded
// into the frame register when the bit position wraps to 0.
// s_valid/s_ready: a frame transfers on any sclk edge where both are high;
// s_ready is a registered "holding buffer empty" flag and never depends on
// s_valid in the same cycle.
// Optional macro I2S_TX_REPEAT_EN: on underrun, keep sending the last loaded
// frame instead of zeros.
module i2s_tx_frame import i2s_pkg::*; #(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = MODE_I2S
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         sdout,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_W);
  localparam int DATA_W     = CHANNELS * SAMPLE_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  logic             tick, frame_wrap;
  logic [CNT_W-1:0] bit_cnt;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              ready_q, ready_d;
  logic              sdout_q, sdout_d;
  logic              lrclk_q, lrclk_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  int                nxt_bit;

  i2s_clkgen #(
    .BCLK_DIV  (BCLK_DIV),
    .FRAME_BITS(FRAME_BITS)
  ) u_clkgen (
    .sclk_i      (sclk),
    .rst_i       (rst),
    .bclk_o      (bclk),
    .tick_o      (tick),
    .bit_cnt_o   (bit_cnt),
    .frame_wrap_o(frame_wrap)
  );

  // Left-justified bit n of a frame: MSB first within each slot, padded with 0
  function automatic logic lj_bit(input logic [DATA_W-1:0] frame, input int n);
    int                slot;
    int                pos;
    logic [DATA_W-1:0] shifted;
    slot    = n / SLOT_W;
    pos     = n % SLOT_W;
    shifted = frame >> (slot * SAMPLE_W + SAMPLE_W - 1 - pos);
    return (pos < SAMPLE_W) ? shifted[0] : 1'b0;
  endfunction

  // Holding buffer handshake and frame load at the wrap tick
  always_comb begin
    hold_d        = hold_q;
    ready_d       = ready_q;
    frame_d       = frame_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    if (s_valid && ready_q) begin
      hold_d  = s_data;
      ready_d = 1'b0;
    end
    if (frame_wrap) begin
      if (!ready_q) begin
        frame_d       = hold_q;
        ready_d       = 1'b1;
        frame_start_d = 1'b1;
      end else begin
        // A frame accepted on this same edge waits for the next load
`ifdef I2S_TX_REPEAT_EN
        frame_d    = frame_q;
`else
        frame_d    = '0;
`endif
        underrun_d = 1'b1;
      end
    end
  end

  // Serial data and word select for the bit position entered on this tick
  always_comb begin
    nxt_bit = frame_wrap ? 0 : int'(bit_cnt) + 1;
    sdout_d = sdout_q;
    lrclk_d = lrclk_q;
    if (tick) begin
      if (MODE == MODE_LJ)  sdout_d = lj_bit(frame_d, nxt_bit);
      else if (frame_wrap)  sdout_d = lj_bit(frame_q, FRAME_BITS - 1);
      else                  sdout_d = lj_bit(frame_q, nxt_bit - 1);
      if (CHANNELS == 2)
        lrclk_d = (MODE == MODE_LJ) ? (nxt_bit / SLOT_W == 0) : (nxt_bit / SLOT_W == 1);
      else
        lrclk_d = (nxt_bit == 0);
    end
  end

  // Registered outputs, buffer and frame state
  always_ff @(posedge sclk) begin
    if (rst) begin
      hold_q        <= '0;
      frame_q       <= '0;
      ready_q       <= 1'b1;
      sdout_q       <= 1'b0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      frame_q       <= frame_d;
      ready_q       <= ready_d;
      sdout_q       <= sdout_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = ready_q;
  assign sdout       = sdout_q;
  assign lrclk       = lrclk_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_frame.sv
// Bench for i2s_tx_frame: three instances (stereo I2S, stereo left-justified,
// 4-channel TDM) share clock, reset and handshake stimulus. Each instance has
// a reference model that builds the frame's bit table from the sample rules.
module tb_i2s_tx_frame;

  localparam int BDIV = 4;

  logic        sclk;
  logic        rst;
  logic        s_valid;
  logic [23:0] smp [4];

  int n_tests;
  int n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Clock
  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH  = (g == 2) ? 4 : 2;
    localparam int SW  = (g == 2) ? 16 : 32;
    localparam int SMW = (g == 2) ? 16 : 24;
    localparam int MD  = (g == 1) ? 1 : 0;
    localparam int FB  = CH * SW;
    localparam int DW  = CH * SMW;

    logic [DW-1:0] s_data;
    logic          s_ready, bclk, lrclk, sdout, frame_start, underrun;

    always_comb begin
      s_data = '0;
      for (int c = 0; c < CH; c++) s_data[c*SMW +: SMW] = smp[c][SMW-1:0];
    end

    i2s_tx_frame #(
      .SAMPLE_W(SMW), .SLOT_W(SW), .CHANNELS(CH), .BCLK_DIV(BDIV), .MODE(MD)
    ) u_dut (
      .sclk(sclk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .bclk(bclk), .lrclk(lrclk), .sdout(sdout), .frame_start(frame_start),
      .underrun(underrun)
    );

    // Scoreboard state
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_f, fr, tmp;
    bit            cur_bits [FB];
    bit            prev_bits [FB];
    int            cyc, pos, last_fall, hi_cnt, falls;
    logic          prev_ready, prev_bclk, exp_sd, exp_lr;
    bit            load, got, acc;

    always @(posedge sclk) begin
      #1;
      if (rst) begin
        cyc = 0; pos = -1; last_fall = 0; hi_cnt = 0; falls = 0;
        prev_ready = 1'b1; prev_bclk = 1'b0; exp_sd = 1'b0; exp_lr = 1'b0;
        exp_q.delete();
        last_f = '0;
        for (int i = 0; i < FB; i++) cur_bits[i] = 1'b0;
        check_eq($sformatf("i%0d rst bclk", g), bclk, 0);
        check_eq($sformatf("i%0d rst lrclk", g), lrclk, 0);
        check_eq($sformatf("i%0d rst sdout", g), sdout, 0);
        check_eq($sformatf("i%0d rst s_ready", g), s_ready, 1);
        check_eq($sformatf("i%0d rst frame_start", g), frame_start, 0);
        check_eq($sformatf("i%0d rst underrun", g), underrun, 0);
      end else begin
        cyc++;
        acc  = s_valid && prev_ready;
        load = 1'b0;
        got  = 1'b0;
        if (prev_bclk && !bclk) begin
          falls++;
          check_eq($sformatf("i%0d bclk period", g), cyc - last_fall, BDIV);
          check_eq($sformatf("i%0d bclk high", g), hi_cnt, BDIV / 2);
          last_fall = cyc;
          hi_cnt    = 0;
          pos = (pos + 1) % FB;
          if (pos == 0) begin
            load = 1'b1;
            for (int i = 0; i < FB; i++) prev_bits[i] = cur_bits[i];
            if (exp_q.size() > 0) begin
              fr     = exp_q.pop_front();
              got    = 1'b1;
              last_f = fr;
            end else begin
`ifdef I2S_TX_REPEAT_EN
              fr = last_f;
`else
              fr = '0;
`endif
            end
            for (int c = 0; c < CH; c++)
              for (int p = 0; p < SW; p++) begin
                if (p < SMW) begin
                  tmp = fr >> (c * SMW + SMW - 1 - p);
                  cur_bits[c*SW + p] = tmp[0];
                end else begin
                  cur_bits[c*SW + p] = 1'b0;
                end
              end
          end
          if (MD == 1)       exp_sd = cur_bits[pos];
          else if (pos == 0) exp_sd = prev_bits[FB-1];
          else               exp_sd = cur_bits[pos-1];
          if (CH == 2) exp_lr = (MD == 1) ? (pos < SW) : (pos >= SW);
          else         exp_lr = (pos == 0);
          check_eq($sformatf("i%0d sdout bit %0d", g, pos), sdout, exp_sd);
          check_eq($sformatf("i%0d lrclk bit %0d", g, pos), lrclk, exp_lr);
        end else begin
          check_eq($sformatf("i%0d sdout hold", g), sdout, exp_sd);
          check_eq($sformatf("i%0d lrclk hold", g), lrclk, exp_lr);
        end
        if (bclk) hi_cnt++;
        check_eq($sformatf("i%0d frame_start", g), frame_start, load && got);
        check_eq($sformatf("i%0d underrun", g), underrun, load && !got);
        if (acc) exp_q.push_back(s_data);
        check_eq($sformatf("i%0d s_ready", g), s_ready, exp_q.size() == 0);
        prev_ready = s_ready;
        prev_bclk  = bclk;
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic rand_smp;
    for (int c = 0; c < 4; c++) smp[c] = 24'($urandom());
  endtask

  task automatic send_frame;
    int n;
    n = 0;
    s_valid = 1'b1;
    while (!g_dut[0].s_ready && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    check_eq("send wait", n < 3000, 1);
    @(negedge sclk);
    s_valid = 1'b0;
  endtask

  // Main sequence
  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    for (int c = 0; c < 4; c++) smp[c] = '0;
    repeat (3) @(negedge sclk);
    rst = 1'b0;

    // No data: underrun every frame, silent output
    idle(600);

    // Directed frames: L=800000 R=000001 (TDM slots 2,3 carry A5A5), then all A5A5
    smp[0] = 24'h800000; smp[1] = 24'h000001; smp[2] = 24'h00A5A5; smp[3] = 24'h00A5A5;
    send_frame();
    idle(300);
    for (int c = 0; c < 4; c++) smp[c] = 24'h00A5A5;
    send_frame();
    idle(300);

    // Random frames, back-to-back and with gaps
    for (int i = 0; i < 8; i++) begin
      rand_smp();
      send_frame();
      idle($urandom_range(0, 150));
    end

    // Offer a frame exactly on the load edge while the buffer is empty
    idle(600);
    n = 0;
    while ((((g_dut[0].cyc + 1 - BDIV) % (BDIV * 64)) != 0) && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    check_eq("align load edge", n < 2000, 1);
    rand_smp();
    s_valid = 1'b1;
    @(negedge sclk);
    s_valid = 1'b0;
    idle(600);

    // Reset in the middle of a frame with a frame pending
    rand_smp();
    send_frame();
    rand_smp();
    send_frame();
    n = 0;
    while (g_dut[0].pos != 37 && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    check_eq("wait bit 37", n < 3000, 1);
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    idle(300);
    rand_smp();
    send_frame();
    idle(600);

    // Bit count consistency since the last reset
    check_eq("i0 falls", g_dut[0].falls, g_dut[0].cyc / BDIV);
    check_eq("i1 falls", g_dut[1].falls, g_dut[1].cyc / BDIV);
    check_eq("i2 falls", g_dut[2].falls, g_dut[2].cyc / BDIV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
